// File: rtl/pm32_stream_if.sv
// Stream and pm32-side signal bundle for pm32_stream.
// slave = the pm32_stream block, master = its environment (producer,
// consumer and the downstream pm32 multiplier).
interface pm32_stream_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_mc;
  logic [31:0] in_mp;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_p;
  logic        err;
  logic        err_clr;
  logic        pm_start;
  logic [31:0] pm_mc;
  logic [31:0] pm_mp;
  logic [63:0] pm_p;
  logic        pm_done;

  modport slave (
    input  in_valid, in_mc, in_mp, out_ready, err_clr, pm_p, pm_done,
    output in_ready, out_valid, out_p, err, pm_start, pm_mc, pm_mp
  );

  modport master (
    output in_valid, in_mc, in_mp, out_ready, err_clr, pm_p, pm_done,
    input  in_ready, out_valid, out_p, err, pm_start, pm_mc, pm_mp
  );
endinterface

// File: rtl/pm32_stream.sv
// pm32_stream: operand FIFO in front of a serial pm32 multiplier.
// Pops one operand pair at a time, pulses pm_start, waits for pm_done
// (bounded by TIMEOUT) and presents the product on a one-deep output slot.
module pm32_stream #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 96
) (
  input  logic         clk,
  input  logic         rst_n,
  pm32_stream_if.slave s
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, BUSY} state_e;

  state_e                         state_q, state_d;
  logic [AW:0]                    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [FIFO_DEPTH-1:0][63:0]    mem_q, mem_d;
  logic [31:0]                    mc_q, mc_d, mp_q, mp_d;
  logic [7:0]                     cnt_q, cnt_d;
  logic                           out_valid_q, out_valid_d;
  logic [63:0]                    out_p_q, out_p_d;
  logic                           err_q, err_d;
  logic                           full, empty, push, pop;
  logic                           capture, timeout, pm_start;

  // Extra wrap bit distinguishes full from empty when indices match.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign push  = s.in_valid && !full;
  assign pop   = (state_q == IDLE) && !empty;

  // FIFO storage and pointer update; push and pop may coincide.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      mem_d[wptr_q[AW-1:0]] = {s.in_mc, s.in_mp};
      wptr_d = wptr_q + PTR_ONE;
    end
    if (pop) rptr_d = rptr_q + PTR_ONE;
  end

  // Next state: operands load on pop and stay put until BUSY is left.
  always_comb begin
    state_d = state_q;
    mc_d    = mc_q;
    mp_d    = mp_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          {mc_d, mp_d} = mem_q[rptr_q[AW-1:0]];
          state_d      = START;
        end
      end
      START: begin
        cnt_d   = 8'd0;
        state_d = BUSY;
      end
      BUSY: begin
        if (s.pm_done) begin
          // Result ready: take it only when the output slot is free; while
          // blocked the timeout counter is frozen.
          if (!out_valid_q || s.out_ready) begin
            capture = 1'b1;
            state_d = IDLE;
          end
        end else if (cnt_q == TO_LAST) begin
          timeout = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: start pulse decoded from the registered state, output slot, sticky err.
  always_comb begin
    pm_start    = (state_q == START);
    out_valid_d = out_valid_q && !s.out_ready;
    out_p_d     = out_p_q;
    if (capture) begin
      out_valid_d = 1'b1;
      out_p_d     = s.pm_p;
    end
    // A timeout on the same edge as err_clr wins.
    err_d = (err_q && !s.err_clr) || timeout;
  end

  // State registers, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      mem_q       <= '0;
      mc_q        <= '0;
      mp_q        <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      mem_q       <= mem_d;
      mc_q        <= mc_d;
      mp_q        <= mp_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_p_q     <= out_p_d;
      err_q       <= err_d;
    end
  end

  assign s.in_ready  = !full;
  assign s.out_valid = out_valid_q;
  assign s.out_p     = out_p_q;
  assign s.err       = err_q;
  assign s.pm_start  = pm_start;
  assign s.pm_mc     = mc_q;
  assign s.pm_mp     = mp_q;
endmodule

// File: doc/pm32_stream.md
PM32_STREAM -- requirements
Module: pm32_stream

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning operand FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT, default 96, meaning max BUSY cycles waiting for pm_done.
REQ-003 SHALL have port clk  input  1  single clock; all flops rise on posedge clk.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand pair valid.
REQ-006 SHALL have port in_ready  output  1  FIFO not full.
REQ-007 SHALL have port in_mc  input  32  signed multiplicand.
REQ-008 SHALL have port in_mp  input  32  signed multiplier.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  result consumer ready.
REQ-011 SHALL have port out_p  output  64  signed product.
REQ-012 SHALL have port err  output  1  sticky timeout flag.
REQ-013 SHALL have port err_clr  input  1  clears err.
REQ-014 SHALL have port pm_start  output  1  start pulse to the downstream pm32 multiplier.
REQ-015 SHALL have port pm_mc  output  32  multiplicand to pm32.
REQ-016 SHALL have port pm_mp  output  32  multiplier to pm32.
REQ-017 SHALL have port pm_p  input  64  pm32 product.
REQ-018 SHALL have port pm_done  input  1  pm32 done level.

Function
REQ-019 SHALL accept an operand pair on any posedge with in_valid && in_ready; in_ready = !fifo_full, independent of in_valid.
REQ-020 SHALL implement the FIFO with wrapping read/write pointers plus one extra wrap bit; full and empty from pointer compare; simultaneous push and pop when full SHALL NOT be accepted (in_ready low); simultaneous push and pop when non-empty and non-full SHALL keep occupancy unchanged.
REQ-021 SHALL implement FSM states IDLE, START, BUSY.
REQ-022 IDLE: if FIFO non-empty, pop head into registers pm_mc/pm_mp and go to START; else stay.
REQ-023 START: pm_start=1 for exactly this one cycle; next state BUSY; pm_start SHALL be a registered-state decode, 0 in all other states.
REQ-024 pm_mc and pm_mp SHALL hold stable from the START cycle until the FSM leaves BUSY (pm32 samples mc serially).
REQ-025 BUSY: count cycles in 8-bit counter, cleared on entry.
REQ-026 BUSY with pm_done=1 and (out_valid=0 or out_ready=1): capture pm_p into out_p, set out_valid, go IDLE.
REQ-027 BUSY with pm_done=1 and out_valid=1 and out_ready=0: stay BUSY holding operands; the timeout counter SHALL NOT advance; capture when the slot frees.
REQ-028 BUSY with pm_done=0 and counter == TIMEOUT-1: set err, discard the operation (no result), go IDLE.
REQ-029 out_valid SHALL clear on out_valid && out_ready unless a new capture occurs the same edge (then it stays 1 with the new out_p).
REQ-030 out_p SHALL change only on capture; stable while out_valid && !out_ready.
REQ-031 err SHALL be set by timeout and cleared by err_clr; a set and a clear on the same edge SHALL leave err=1.
REQ-032 Minimum latency: pair accepted at edge N into empty FIFO with FSM in IDLE -> popped at N+1, pm_start high during cycle N+1..N+2, out_valid high after the edge where pm_done is first seen.
REQ-033 Only one operation SHALL be outstanding at pm32; pm_done high while in IDLE or START SHALL be ignored.

Reset
REQ-034 On rst_n low, asynchronously: FSM=IDLE, FIFO empty, in_ready=1, out_valid=0, out_p=0, err=0, pm_start=0, pm_mc=0, pm_mp=0, counter=0.
REQ-035 Reset mid-BUSY SHALL drop the in-flight operation and all queued pairs; no result is produced after release.

Verification
REQ-036 in 3 x 5 with out_ready=1 and real pm32 -> one pm_start pulse; out_p=64'd15, out_valid one cycle.
REQ-037 in 32'hFFFFFFFF x 32'hFFFFFFFF, then 32'h80000000 x 32'd2 back-to-back -> out_p=64'h1 then 64'hFFFFFFFF00000000, in order, two pm_start pulses.
REQ-038 push 6 pairs with out_ready=0 -> in_ready drops after 4 queued plus 1 popped; first result held stable; releasing out_ready drains all 6 in order with no loss or duplicate.
REQ-039 stub pm_done=0 permanently -> err=1 exactly 96 BUSY cycles after START, no out_valid; err_clr -> err=0; next pair proceeds.
REQ-040 assert rst_n=0 midway through BUSY with 2 pairs queued -> all outputs at reset values immediately; no out_valid after release until new input.
